// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one combinational alu among NUM_REQ requesters
//   riscv_pkg    : XLEN and alu_op_e shared with the alu and its requesters
//   clk_i/rst_ni : clock, synchronous active-low reset
//   req_*        : per-requester valid/ready handshake, operands and operation
//   rsp_*        : per-requester registered result/flags {overflow, carry, negative, zero}
//   alu_*        : operands/op to the shared alu and its combinational result/flags
package riscv_pkg;
    localparam int XLEN = 32;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_AND,
        ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA
    } alu_op_e;
endpackage

module alu_arbiter
    import riscv_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic    [NUM_REQ-1:0]             req_valid_i,
    output logic    [NUM_REQ-1:0]             req_ready_o,
    input  logic    [NUM_REQ-1:0][XLEN-1:0]   req_a_i,
    input  logic    [NUM_REQ-1:0][XLEN-1:0]   req_b_i,
    input  alu_op_e [NUM_REQ-1:0]             req_op_i,
    output logic    [NUM_REQ-1:0]             rsp_valid_o,
    input  logic    [NUM_REQ-1:0]             rsp_ready_i,
    output logic    [NUM_REQ-1:0][XLEN-1:0]   rsp_result_o,
    output logic    [NUM_REQ-1:0][3:0]        rsp_flags_o,
    output logic    [XLEN-1:0]                alu_a_o,
    output logic    [XLEN-1:0]                alu_b_o,
    output alu_op_e                           alu_op_o,
    input  logic    [XLEN-1:0]                alu_result_i,
    input  logic                              alu_zero_i,
    input  logic                              alu_negative_i,
    input  logic                              alu_carry_i,
    input  logic                              alu_overflow_i
);
    localparam int PW = $clog2(NUM_REQ);

    logic [PW-1:0]                 r_ptr;
    logic [NUM_REQ-1:0]            r_vld;
    logic [NUM_REQ-1:0][XLEN-1:0]  r_res;
    logic [NUM_REQ-1:0][3:0]       r_flg;
    logic [NUM_REQ-1:0]            w_elig;
    logic [NUM_REQ-1:0]            w_gnt;
    logic [PW-1:0]                 w_idx;
    logic [PW-1:0]                 w_j;
    logic                          w_any;
    logic                          w_fire;

    // a slot can take a new result when empty or being drained this cycle
    assign w_elig = req_valid_i & (~r_vld | rsp_ready_i);

    // first eligible requester at or after r_ptr, wrapping
    always_comb begin
        w_any = 1'b0;
        w_idx = '0;
        w_j   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_j = PW'((int'(r_ptr) + k) % NUM_REQ);
            if (!w_any && w_elig[w_j]) begin
                w_any = 1'b1;
                w_idx = w_j;
            end
        end
    end

    // no grant while in reset, so nothing is accepted on the reset edge
    assign w_fire      = w_any && rst_ni;
    assign w_gnt       = w_fire ? (NUM_REQ'(1) << w_idx) : '0;
    assign req_ready_o = w_gnt;
    assign alu_a_o     = w_fire ? req_a_i[w_idx] : '0;
    assign alu_b_o     = w_fire ? req_b_i[w_idx] : '0;
    assign alu_op_o    = w_fire ? req_op_i[w_idx] : ALU_ADD;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_ptr <= '0;
            r_vld <= '0;
            r_res <= '0;
            r_flg <= '0;
        end else begin
            // a refill of a draining slot keeps it valid with the new data
            r_vld <= (r_vld & ~rsp_ready_i) | w_gnt;
            if (w_fire) begin
                r_ptr        <= PW'((int'(w_idx) + 1) % NUM_REQ);
                r_res[w_idx] <= alu_result_i;
                r_flg[w_idx] <= {alu_overflow_i, alu_carry_i, alu_negative_i, alu_zero_i};
            end
        end
    end

    assign rsp_valid_o  = r_vld;
    assign rsp_result_o = r_res;
    assign rsp_flags_o  = r_flg;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized and directed check of alu_arbiter against a round-robin reference model
module tb_alu_arbiter;
    import riscv_pkg::*;
    localparam int N = 3;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic    [N-1:0]           req_valid = '0;
    logic    [N-1:0]           req_ready;
    logic    [N-1:0][31:0]     req_a = '0;
    logic    [N-1:0][31:0]     req_b = '0;
    alu_op_e [N-1:0]           req_op;
    logic    [N-1:0]           rsp_valid;
    logic    [N-1:0]           rsp_ready = '0;
    logic    [N-1:0][31:0]     rsp_result;
    logic    [N-1:0][3:0]      rsp_flags;
    logic    [31:0]            alu_a, alu_b, alu_result;
    alu_op_e                   alu_op;
    logic                      alu_z, alu_n, alu_c, alu_v;

    int n_chk = 0;
    int n_fail = 0;
    int m_ptr = 0;
    logic [N-1:0] m_vld = '0;
    logic [31:0]  m_res [N];
    logic [3:0]   m_flg [N];
    logic [N-1:0] last_rdy;
    logic [31:0]  held;

    alu_arbiter #(.NUM_REQ(N)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_a_i(req_a), .req_b_i(req_b), .req_op_i(req_op),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_result_o(rsp_result), .rsp_flags_o(rsp_flags),
        .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op),
        .alu_result_i(alu_result), .alu_zero_i(alu_z), .alu_negative_i(alu_n),
        .alu_carry_i(alu_c), .alu_overflow_i(alu_v)
    );

    always #5 clk = ~clk;

    // returns {overflow, carry, negative, zero, result}; carry on SUB means borrow
    function automatic logic [35:0] ref_alu(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        logic [31:0] r;
        logic c, v;
        c = 1'b0;
        v = 1'b0;
        case (op)
            ALU_ADD:  begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32]; v = (a[31] == b[31]) && (r[31] != a[31]); end
            ALU_SUB:  begin r = a - b; c = a < b; v = (a[31] != b[31]) && (r[31] != a[31]); end
            ALU_SLT:  r = {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU: r = {31'd0, a < b};
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_XOR:  r = a ^ b;
            ALU_SLL:  r = a << b[4:0];
            ALU_SRL:  r = a >> b[4:0];
            default:  r = $signed(a) >>> b[4:0];
        endcase
        return {v, c, r[31], r == 32'd0, r};
    endfunction

    always_comb {alu_v, alu_c, alu_n, alu_z, alu_result} = ref_alu(alu_op, alu_a, alu_b);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // check outputs against the model mid-cycle, then advance the model over the next edge
    task automatic tick();
        int g;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        g = -1;
        if (rst_n)
            for (int k = 0; k < N; k++) begin
                int idx = (m_ptr + k) % N;
                if (g < 0 && req_valid[idx] && (!m_vld[idx] || rsp_ready[idx])) g = idx;
            end
        exp_rdy = (g >= 0) ? N'(1) << g : '0;
        last_rdy = req_ready;
        chk("req_ready", req_ready, exp_rdy);
        chk("rsp_valid", rsp_valid, m_vld);
        for (int i = 0; i < N; i++) begin
            chk("rsp_result", rsp_result[i], m_res[i]);
            chk("rsp_flags", rsp_flags[i], m_flg[i]);
        end
        chk("alu_a", alu_a, (g >= 0) ? req_a[g] : 32'd0);
        chk("alu_b", alu_b, (g >= 0) ? req_b[g] : 32'd0);
        chk("alu_op", alu_op, (g >= 0) ? req_op[g] : ALU_ADD);
        if (!rst_n) begin
            m_ptr = 0;
            m_vld = '0;
            for (int i = 0; i < N; i++) begin
                m_res[i] = '0;
                m_flg[i] = '0;
            end
        end else begin
            m_vld = m_vld & ~rsp_ready;
            if (g >= 0) begin
                {m_flg[g], m_res[g]} = ref_alu(req_op[g], req_a[g], req_b[g]);
                m_vld[g] = 1'b1;
                m_ptr = (g + 1) % N;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            req_op[i] = ALU_ADD;
            m_res[i] = '0;
            m_flg[i] = '0;
        end
        tick();
        tick();
        chk("reset_valid", rsp_valid, 0);
        rst_n = 1'b1;
        rsp_ready = '1;

        req_valid = 3'b001; req_a[0] = 32'd5; req_b[0] = 32'd7; req_op[0] = ALU_ADD;
        tick();
        chk("single_ready", last_rdy, 3'b001);
        req_valid = '0;
        chk("single_valid", rsp_valid[0], 1);
        chk("single_result", rsp_result[0], 12);
        chk("single_flags", rsp_flags[0], 4'b0000);

        req_valid = 3'b011; req_op[1] = ALU_SUB; req_a[1] = 32'd9; req_b[1] = 32'd4;
        tick(); chk("contend_g0", last_rdy, 3'b010);
        tick(); chk("contend_g1", last_rdy, 3'b001);
        tick(); chk("contend_g2", last_rdy, 3'b010);
        tick(); chk("contend_g3", last_rdy, 3'b001);

        rsp_ready = 3'b110;
        held = rsp_result[0];
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_grant1", last_rdy, 3'b010);
            chk("bp_hold0", rsp_result[0], held);
        end
        rsp_ready = '1;
        tick(); chk("bp_release", last_rdy, 3'b001);

        req_valid = 3'b010; req_op[1] = ALU_SUB; req_a[1] = 32'h8000_0000; req_b[1] = 32'd1;
        tick();
        chk("flags_result", rsp_result[1], 32'h7FFF_FFFF);
        chk("flags_flags", rsp_flags[1], 4'b1000);

        req_valid = 3'b001; req_op[0] = ALU_ADD; req_a[0] = 32'd1; req_b[0] = 32'd1;
        tick();
        req_op[0] = ALU_SLT; req_a[0] = 32'hFFFF_FFFF; req_b[0] = 32'd0;
        tick();
        chk("refill_valid", rsp_valid[0], 1);
        chk("refill_result", rsp_result[0], 1);

        req_valid = 3'b011; rst_n = 1'b0;
        tick();
        chk("rst_ready", last_rdy, 0);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_result0", rsp_result[0], 0);
        rst_n = 1'b1;
        tick();
        chk("rst_first_grant", last_rdy, 3'b001);

        for (int c = 0; c < 600; c++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            req_valid = N'($urandom);
            rsp_ready = N'($urandom);
            for (int i = 0; i < N; i++) begin
                if (!(req_valid[i] && !req_ready[i])) begin
                    req_a[i] = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
                    req_b[i] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
                    req_op[i] = alu_op_e'($urandom_range(0, 9));
                end
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
